calc_core_seq: RTL and testbench
================================

Name: calc_core_seq

Overview:
Parametrised sequential arithmetic engine for the slide-switch/push-button calculator family. It generalises operand width and display digit count, and adds iterative multiply/divide, decimal-range overflow detection and result chaining. It sits between the debounced button pulse generators and the digit separator / 7-segment decoders.

Parameters:
WIDTH, 40, internal operand/result magnitude width in bits (>= IN_W+1).
DIGITS, 6, displayable decimal digits; MAX = 10^DIGITS-1, which must be < 2^WIDTH.
IN_W, 6, operand entry width from the switches, zero-extended to WIDTH.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
in_val  in  IN_W  operand value from the switches
op  in  2  operation: 00 add, 01 sub, 10 mul, 11 div; sampled when B is latched
enter_p  in  1  one-cycle enter pulse
clear_p  in  1  one-cycle clear pulse
chain_en  in  1  when 1, enter in SHOW reuses the result as operand A
result  out  WIDTH  result magnitude
res_sign  out  1  result sign (1 = negative)
err  out  1  error flag (overflow or divide by zero)
busy  out  1  high while in COMPUTE
done  out  1  one-cycle pulse when the result is written
disp_sel  out  2  display source: 00 A entry, 01 B entry, 10 busy, 11 result/error
led  out  4  one-hot state: 0001 ENTER_A, 0010 ENTER_B, 0100 COMPUTE, 1000 SHOW or ERROR

Behaviour:
- Reset (rst_n=0 at a clk edge): state ENTER_A; A, B, result = 0; res_sign, err, busy, done = 0; disp_sel = 00; led = 0001.
- Operands are held as sign-magnitude. A carries sign_a; B is always non-negative.
- ENTER_A: enter_p latches A = in_val with sign_a = 0, then go to ENTER_B.
- ENTER_B: enter_p latches B = in_val and op, then go to COMPUTE.
- COMPUTE, add/sub: evaluated in WIDTH+1-bit two's complement from the signed A and B. Result is written 1 cycle after entering COMPUTE.
- COMPUTE, mul: shift-add, exactly WIDTH iterations. res_sign = sign_a.
- COMPUTE, div: restoring division, exactly WIDTH iterations. Quotient truncates toward zero; remainder is discarded. res_sign = sign_a.
- Latency from the B-latching enter (cycle n): add/sub result and done at n+2; mul/div at n+2+WIDTH.
- Range check on write: |value| > MAX, or an intermediate carry out of WIDTH, goes to ERROR with err=1 and result=0.
- Divide with B=0 goes directly to ERROR at the first COMPUTE cycle.
- A zero result always has res_sign = 0.
- SHOW: result is held. On enter_p:
  - chain_en=1: A = result, sign_a = res_sign, go to ENTER_B.
  - chain_en=0: clear A, B, result and sign, go to ENTER_A.
- ERROR: only clear_p or rst_n leaves it; enter_p is ignored.
- clear_p in any state, including mid-COMPUTE: next cycle is ENTER_A with all registers zeroed and busy=0. Any in-flight iteration is abandoned; no done pulse.
- Simultaneous clear_p and enter_p: clear wins.
- enter_p during COMPUTE is ignored and not queued.
- done is high for exactly one cycle, coincident with the first SHOW/ERROR cycle.

Optional Feature:
CALC_SAT_EN
- Defined: overflow saturates result to MAX, keeps the computed sign, and goes to SHOW with err=0. Divide by zero still goes to ERROR.
- Undefined: overflow goes to ERROR as described above.

Decomposition:
- Package calc_pkg holds:
  - op encoding constants OP_ADD, OP_SUB, OP_MUL, OP_DIV;
  - state encoding for ENTER_A, ENTER_B, COMPUTE, SHOW, ERROR;
  - disp_sel codes;
  - a constant function computing MAX from DIGITS.
- Sub-module calc_muldiv_iter: iterative WIDTH-cycle multiply/divide unit with start/done handshake, a divide-by-zero flag and a synchronous abort input driven by clear.

Test Plan:
- 25 enter, 17 enter, op=00 -> result=42, sign=0, done 2 cycles after the second enter, led 0100 -> 1000.
- 5, 9, op=01 -> result=4, res_sign=1; a separate 9-9 run -> result=0, sign=0.
- 63*63 (op=10) -> result=3969 exactly WIDTH+2 cycles after enter, busy high WIDTH+1 cycles. Then 50/7 (op=11) -> 7.
- 7/0 -> err=1, state ERROR, result=0; enter ignored; clear -> ENTER_A, err=0.
- Chain with chain_en=1: 63*63=3969, *63=250047, *63 overflows.
  - Without macro: err=1.
  - With CALC_SAT_EN: result=999999, err=0.
- Clear at iteration 10 of a divide -> ENTER_A next cycle, no done pulse. Simultaneous enter+clear in ENTER_B -> ENTER_A and B not latched.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared encodings for the sequential calculator core: op codes, FSM states,
// display-source codes, LED patterns and the decimal range limit helper.
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        ST_ENTER_A = 3'd0,
        ST_ENTER_B = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_SHOW    = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;

    localparam logic [1:0] DISP_A    = 2'b00;
    localparam logic [1:0] DISP_B    = 2'b01;
    localparam logic [1:0] DISP_BUSY = 2'b10;
    localparam logic [1:0] DISP_RES  = 2'b11;

    localparam logic [3:0] LED_A   = 4'b0001;
    localparam logic [3:0] LED_B   = 4'b0010;
    localparam logic [3:0] LED_CMP = 4'b0100;
    localparam logic [3:0] LED_RES = 4'b1000;

    // Largest value representable with the given number of decimal digits.
    function automatic longint unsigned calc_max(input int unsigned digits);
        longint unsigned m;
        m = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            m = m * 64'd10;
        end
        return m - 64'd1;
    endfunction

endpackage

// File: rtl/calc_muldiv_iter.sv
// Iterative unsigned multiply (MSB-first shift-add) and restoring divide.
// The start cycle performs the first iteration, so done pulses one cycle
// after the WIDTH-th iteration. A zero divisor is flagged on start and the
// unit does not launch. abort is a synchronous cancel.
module calc_muldiv_iter #(
    parameter int unsigned WIDTH = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             ovf,
    output logic             dbz_c
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    // acc: product / remainder; opr: multiplier / dividend->quotient; mc: multiplicand / divisor
    logic [WIDTH-1:0] acc, opr, mc;
    logic             ov, running, div_r;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] cur_acc, cur_opr, cur_mc;
    logic             cur_div, cur_ov;
    logic [WIDTH-1:0] nxt_acc, nxt_opr;
    logic             nxt_ov;
    logic [WIDTH+1:0] msum;
    logic [WIDTH:0]   rsh;
    logic [WIDTH-1:0] rdiff;
    logic             go;

    assign dbz_c = start && is_div && (b == '0);
    assign go    = (start && !dbz_c) || running;
    assign res   = div_r ? opr : acc;
    assign ovf   = ov;

    // Operand source: fresh inputs on start, otherwise the working registers
    always_comb begin
        cur_acc = acc;
        cur_opr = opr;
        cur_mc  = mc;
        cur_div = div_r;
        cur_ov  = ov;
        if (start) begin
            cur_acc = '0;
            cur_opr = is_div ? a : b;
            cur_mc  = is_div ? b : a;
            cur_div = is_div;
            cur_ov  = 1'b0;
        end
    end

    // One multiply or divide step; multiply records any carry beyond WIDTH
    always_comb begin
        msum    = {1'b0, cur_acc, 1'b0} + (cur_opr[WIDTH-1] ? {2'b00, cur_mc} : '0);
        rsh     = {cur_acc, cur_opr[WIDTH-1]};
        rdiff   = rsh[WIDTH-1:0] - cur_mc;
        nxt_acc = cur_acc;
        nxt_opr = cur_opr;
        nxt_ov  = cur_ov;
        if (cur_div) begin
            if (rsh >= {1'b0, cur_mc}) begin
                nxt_acc = rdiff;
                nxt_opr = {cur_opr[WIDTH-2:0], 1'b1};
            end else begin
                nxt_acc = rsh[WIDTH-1:0];
                nxt_opr = {cur_opr[WIDTH-2:0], 1'b0};
            end
        end else begin
            nxt_acc = msum[WIDTH-1:0];
            nxt_opr = {cur_opr[WIDTH-2:0], 1'b0};
            nxt_ov  = cur_ov | (|msum[WIDTH+1:WIDTH]);
        end
    end

    // Working registers and iteration counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            opr     <= '0;
            mc      <= '0;
            ov      <= 1'b0;
            div_r   <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
        end else if (abort) begin
            running <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            if (go) begin
                acc   <= nxt_acc;
                opr   <= nxt_opr;
                mc    <= cur_mc;
                div_r <= cur_div;
                ov    <= nxt_ov;
            end
            if (start && !dbz_c) begin
                cnt     <= CNT_W'(1);
                running <= 1'b1;
            end else if (running) begin
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/calc_core_seq.sv
// Sequential calculator core: operand entry, add/sub in one cycle,
// iterative mul/div, decimal range check and result chaining.
// Build option CALC_SAT_EN: range overflow saturates to MAX instead of
// entering ERROR (divide by zero still errors).
module calc_core_seq
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH  = 40,
    parameter int unsigned DIGITS = 6,
    parameter int unsigned IN_W   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in_val,
    input  logic [1:0]       op,
    input  logic             enter_p,
    input  logic             clear_p,
    input  logic             chain_en,
    output logic [WIDTH-1:0] result,
    output logic             res_sign,
    output logic             err,
    output logic             busy,
    output logic             done,
    output logic [1:0]       disp_sel,
    output logic [3:0]       led
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(calc_max(DIGITS));

    state_t           state, state_d;
    logic [WIDTH-1:0] a_r, b_r, in_ext;
    logic             sign_a;
    logic [1:0]       op_r;
    logic             first;

    logic [3:0]       led_d;
    logic [1:0]       disp_d;
    logic             busy_d;

    logic             md_start_c, md_is_div, md_done, md_ovf, md_dbz_c;
    logic [WIDTH-1:0] md_res;

    logic [WIDTH+1:0] as_a, as_sum, as_abs;
    logic             as_neg, as_carry;
    logic [WIDTH-1:0] as_mag;

    logic [WIDTH-1:0] val, wr_val;
    logic             val_sign, val_carry, over, wr_c, wr_err, wr_sign;

    assign in_ext     = WIDTH'(in_val);
    assign md_is_div  = (op_r == OP_DIV);
    assign md_start_c = (state == ST_COMPUTE) && first && op_r[1] && !clear_p;

    calc_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start_c),
        .abort  (clear_p),
        .is_div (md_is_div),
        .a      (a_r),
        .b      (b_r),
        .done   (md_done),
        .res    (md_res),
        .ovf    (md_ovf),
        .dbz_c  (md_dbz_c)
    );

    // Signed add/sub with two guard bits, folded back to sign-magnitude
    always_comb begin
        as_a     = sign_a ? -{2'b00, a_r} : {2'b00, a_r};
        as_sum   = (op_r == OP_SUB) ? (as_a - {2'b00, b_r}) : (as_a + {2'b00, b_r});
        as_neg   = as_sum[WIDTH+1];
        as_abs   = as_neg ? -as_sum : as_sum;
        as_mag   = as_abs[WIDTH-1:0];
        as_carry = |as_abs[WIDTH+1:WIDTH];
    end

    // Result selection, range check and write-back values
    always_comb begin
        val       = op_r[1] ? md_res : as_mag;
        val_sign  = op_r[1] ? sign_a : as_neg;
        val_carry = op_r[1] ? md_ovf : as_carry;
        over      = val_carry || (val > MAX);
        wr_c      = (state == ST_COMPUTE) && (op_r[1] ? (md_dbz_c || md_done) : 1'b1);
        wr_err    = 1'b0;
        wr_val    = val;
        if (md_dbz_c) begin
            wr_err = 1'b1;
            wr_val = '0;
        end else if (over) begin
`ifdef CALC_SAT_EN
            wr_val = MAX;
`else
            wr_err = 1'b1;
            wr_val = '0;
`endif
        end
        wr_sign = !wr_err && (wr_val != '0) && val_sign;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_ENTER_A;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic; clear overrides everything
    always_comb begin
        state_d = state;
        if (clear_p) begin
            state_d = ST_ENTER_A;
        end else begin
            case (state)
                ST_ENTER_A: if (enter_p) state_d = ST_ENTER_B;
                ST_ENTER_B: if (enter_p) state_d = ST_COMPUTE;
                ST_COMPUTE: if (wr_c) state_d = wr_err ? ST_ERROR : ST_SHOW;
                ST_SHOW:    if (enter_p) state_d = chain_en ? ST_ENTER_B : ST_ENTER_A;
                ST_ERROR:   state_d = ST_ERROR;
                default:    state_d = ST_ENTER_A;
            endcase
        end
    end

    // Status decode from the upcoming state so the registered outputs track it
    always_comb begin
        led_d  = LED_A;
        disp_d = DISP_A;
        busy_d = 1'b0;
        case (state_d)
            ST_ENTER_B: begin
                led_d  = LED_B;
                disp_d = DISP_B;
            end
            ST_COMPUTE: begin
                led_d  = LED_CMP;
                disp_d = DISP_BUSY;
                busy_d = 1'b1;
            end
            ST_SHOW, ST_ERROR: begin
                led_d  = LED_RES;
                disp_d = DISP_RES;
            end
            default: ;
        endcase
    end

    // Operand, result and status registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r      <= '0;
            sign_a   <= 1'b0;
            b_r      <= '0;
            op_r     <= OP_ADD;
            first    <= 1'b0;
            result   <= '0;
            res_sign <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            disp_sel <= DISP_A;
            led      <= LED_A;
        end else begin
            led      <= led_d;
            disp_sel <= disp_d;
            busy     <= busy_d;
            done     <= 1'b0;
            first    <= (state != ST_COMPUTE) && (state_d == ST_COMPUTE);
            if (clear_p) begin
                a_r      <= '0;
                sign_a   <= 1'b0;
                b_r      <= '0;
                op_r     <= OP_ADD;
                result   <= '0;
                res_sign <= 1'b0;
                err      <= 1'b0;
            end else begin
                case (state)
                    ST_ENTER_A: begin
                        if (enter_p) begin
                            a_r    <= in_ext;
                            sign_a <= 1'b0;
                        end
                    end
                    ST_ENTER_B: begin
                        if (enter_p) begin
                            b_r  <= in_ext;
                            op_r <= op;
                        end
                    end
                    ST_COMPUTE: begin
                        if (wr_c) begin
                            result   <= wr_val;
                            res_sign <= wr_sign;
                            err      <= wr_err;
                            done     <= 1'b1;
                        end
                    end
                    ST_SHOW: begin
                        if (enter_p) begin
                            if (chain_en) begin
                                a_r    <= result;
                                sign_a <= res_sign;
                            end else begin
                                a_r      <= '0;
                                sign_a   <= 1'b0;
                                b_r      <= '0;
                                result   <= '0;
                                res_sign <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_core_seq.sv
// Self-checking bench for calc_core_seq: directed operations against a
// plain-arithmetic model of the calculator, with per-cycle done/busy checks.
module tb_calc_core_seq;

    localparam int unsigned W    = 40;
    localparam int unsigned DIG  = 6;
    localparam int unsigned IN_W = 6;

    localparam logic [1:0] ADD = 2'd0;
    localparam logic [1:0] SUB = 2'd1;
    localparam logic [1:0] MUL = 2'd2;
    localparam logic [1:0] DIV = 2'd3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [IN_W-1:0] in_val;
    logic [1:0]      op;
    logic            enter_p, clear_p, chain_en;
    logic [W-1:0]    result;
    logic            res_sign, err, busy, done;
    logic [1:0]      disp_sel;
    logic [3:0]      led;

    calc_core_seq #(.WIDTH(W), .DIGITS(DIG), .IN_W(IN_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_val   (in_val),
        .op       (op),
        .enter_p  (enter_p),
        .clear_p  (clear_p),
        .chain_en (chain_en),
        .result   (result),
        .res_sign (res_sign),
        .err      (err),
        .busy     (busy),
        .done     (done),
        .disp_sel (disp_sel),
        .led      (led)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int     n_tests = 0;
    int     n_fail  = 0;
    bit     mon_en  = 1'b0;
    longint maxv;
    longint ma      = 0;
    longint e_start = -1;
    longint e_done  = -1;
    longint e_mag   = 0;
    bit     e_sg    = 1'b0;
    bit     e_er    = 1'b0;
    int     nb;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected outcome straight from the calculator rules
    function automatic void model(input longint sa, input longint b, input logic [1:0] o,
                                  output longint mag, output bit sg, output bit er);
        longint v;
        er = 1'b0;
        case (o)
            ADD: v = sa + b;
            SUB: v = sa - b;
            MUL: v = sa * b;
            default: begin
                if (b == 0) begin
                    er = 1'b1;
                    v  = 0;
                end else begin
                    v = sa / b;
                end
            end
        endcase
        mag = (v < 0) ? -v : v;
        sg  = (v < 0);
        if (!er && mag > maxv) begin
`ifdef CALC_SAT_EN
            mag = maxv;
`else
            er  = 1'b1;
            mag = 0;
            sg  = 1'b0;
`endif
        end
        if (mag == 0) sg = 1'b0;
    endfunction

    // Per-cycle compare of the handshake and of the written result
    always @(negedge clk) begin
        if (mon_en) begin
            chk("done", 64'(done), 64'(cyc == e_done));
            chk("busy", 64'(busy), 64'(cyc >= e_start && cyc < e_done));
            if (cyc == e_done) begin
                chk("result", 64'(result), 64'(e_mag));
                chk("res_sign", 64'(res_sign), 64'(e_sg));
                chk("err", 64'(err), 64'(e_er));
                chk("led_res", 64'(led), 64'(4'b1000));
                chk("disp_res", 64'(disp_sel), 64'(2'b11));
            end
        end
    end

    task automatic pulse(input logic [IN_W-1:0] v, input logic [1:0] o,
                         input bit ch, input bit en, input bit cl);
        @(posedge clk);
        #1;
        in_val   = v;
        op       = o;
        chain_en = ch;
        enter_p  = en;
        clear_p  = cl;
        @(posedge clk);
        #1;
        enter_p  = 1'b0;
        clear_p  = 1'b0;
    endtask

    task automatic enter_a(input logic [IN_W-1:0] v);
        pulse(v, ADD, 1'b0, 1'b1, 1'b0);
        ma = longint'(v);
    endtask

    task automatic issue_b(input logic [IN_W-1:0] v, input logic [1:0] o);
        longint m;
        bit s, e;
        pulse(v, o, 1'b0, 1'b1, 1'b0);
        model(ma, longint'(v), o, m, s, e);
        e_mag   = m;
        e_sg    = s;
        e_er    = e;
        e_start = cyc;
        e_done  = cyc + 1 + (((o == MUL) || (o == DIV && v != 0)) ? longint'(W) : 0);
    endtask

    task automatic wait_done(output int nbusy);
        nbusy = 0;
        while (cyc < e_done) begin
            @(negedge clk);
            if (busy) nbusy++;
        end
    endtask

    task automatic do_op(input logic [IN_W-1:0] v, input logic [1:0] o);
        int n;
        issue_b(v, o);
        wait_done(n);
    endtask

    task automatic show_enter(input bit ch);
        pulse('0, ADD, ch, 1'b1, 1'b0);
        if (ch && !e_er) ma = e_sg ? -e_mag : e_mag;
        else ma = 0;
    endtask

    task automatic do_clear();
        pulse('0, ADD, 1'b0, 1'b0, 1'b1);
        e_start = -1;
        e_done  = -1;
        ma      = 0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        in_val   = '0;
        op       = 2'b00;
        enter_p  = 1'b0;
        clear_p  = 1'b0;
        chain_en = 1'b0;
        maxv = 1;
        repeat (DIG) maxv = maxv * 10;
        maxv = maxv - 1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_sign", 64'(res_sign), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_disp", 64'(disp_sel), 64'd0);
        chk("rst_led", 64'(led), 64'(4'b0001));
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // 25 + 17
        enter_a(6'd25);
        chk("led_enter_b", 64'(led), 64'(4'b0010));
        chk("disp_enter_b", 64'(disp_sel), 64'(2'b01));
        issue_b(6'd17, ADD);
        chk("led_compute", 64'(led), 64'(4'b0100));
        chk("disp_busy", 64'(disp_sel), 64'(2'b10));
        wait_done(nb);
        chk("lit_add", 64'(result), 64'd42);
        chk("add_busy_cycles", 64'(nb), 64'd1);
        show_enter(1'b0);
        chk("led_back_a", 64'(led), 64'(4'b0001));
        chk("show_clear_result", 64'(result), 64'd0);

        // 5 - 9 and 9 - 9
        enter_a(6'd5);
        do_op(6'd9, SUB);
        chk("lit_sub", 64'(result), 64'd4);
        chk("lit_sub_sign", 64'(res_sign), 64'd1);
        show_enter(1'b0);
        enter_a(6'd9);
        do_op(6'd9, SUB);
        chk("lit_zero", 64'(result), 64'd0);
        chk("lit_zero_sign", 64'(res_sign), 64'd0);
        show_enter(1'b0);

        // 63 * 63, then 50 / 7
        enter_a(6'd63);
        issue_b(6'd63, MUL);
        wait_done(nb);
        chk("lit_mul", 64'(result), 64'd3969);
        chk("mul_busy_cycles", 64'(nb), 64'(W + 1));
        show_enter(1'b0);
        enter_a(6'd50);
        do_op(6'd7, DIV);
        chk("lit_div", 64'(result), 64'd7);
        show_enter(1'b0);

        // 7 / 0, enter ignored in ERROR, clear recovers
        enter_a(6'd7);
        do_op(6'd0, DIV);
        chk("dbz_err", 64'(err), 64'd1);
        chk("dbz_result", 64'(result), 64'd0);
        pulse(6'd3, ADD, 1'b1, 1'b1, 1'b0);
        chk("err_hold_led", 64'(led), 64'(4'b1000));
        chk("err_hold_err", 64'(err), 64'd1);
        do_clear();
        chk("clr_led", 64'(led), 64'(4'b0001));
        chk("clr_err", 64'(err), 64'd0);

        // Chained multiplies up to overflow
        enter_a(6'd63);
        do_op(6'd63, MUL);
        show_enter(1'b1);
        chk("chain_led", 64'(led), 64'(4'b0010));
        do_op(6'd63, MUL);
        chk("lit_chain_mul", 64'(result), 64'd250047);
        show_enter(1'b1);
        do_op(6'd63, MUL);
`ifdef CALC_SAT_EN
        chk("lit_sat_result", 64'(result), 64'd999999);
        chk("lit_sat_err", 64'(err), 64'd0);
`else
        chk("lit_ovf_err", 64'(err), 64'd1);
        chk("lit_ovf_result", 64'(result), 64'd0);
`endif
        do_clear();

        // Signed chaining: 5-9=-4, *3=-12, /5=-2, +2=0
        enter_a(6'd5);
        do_op(6'd9, SUB);
        show_enter(1'b1);
        do_op(6'd3, MUL);
        chk("lit_neg_mul", 64'(result), 64'd12);
        chk("lit_neg_mul_sign", 64'(res_sign), 64'd1);
        show_enter(1'b1);
        do_op(6'd5, DIV);
        chk("lit_neg_div", 64'(result), 64'd2);
        chk("lit_neg_div_sign", 64'(res_sign), 64'd1);
        show_enter(1'b1);
        do_op(6'd2, ADD);
        chk("lit_neg_add", 64'(result), 64'd0);
        chk("lit_neg_add_sign", 64'(res_sign), 64'd0);
        show_enter(1'b0);

        // Clear at iteration 10 of a divide
        enter_a(6'd50);
        issue_b(6'd7, DIV);
        repeat (8) @(posedge clk);
        do_clear();
        chk("abort_led", 64'(led), 64'(4'b0001));
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_result", 64'(result), 64'd0);
        repeat (W + 5) @(negedge clk);
        chk("abort_led_late", 64'(led), 64'(4'b0001));

        // Enter and clear together in ENTER_B
        enter_a(6'd5);
        pulse(6'd9, ADD, 1'b0, 1'b1, 1'b1);
        ma = 0;
        chk("enter_clr_led", 64'(led), 64'(4'b0001));
        chk("enter_clr_disp", 64'(disp_sel), 64'(2'b00));
        enter_a(6'd3);
        do_op(6'd4, ADD);
        chk("lit_after_clr", 64'(result), 64'd7);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
